// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
//
// This is the final stage of the CNN inference pipeline. On a one-cycle trmt
// pulse it latches the classified digit from the output layer. It then sends
// the digit as an ASCII character over an 8N1 UART line. When SEND_CRLF is set,
// the character is followed by CR and LF, so the host terminal shows one line
// per inference.
//
// Parameters
//   BAUD_DIV  : clk cycles per UART bit (2..65535). The default suits
//               50 MHz / 115200 baud.
//   SEND_CRLF : 1 sends char, 0x0D, 0x0A. 0 sends the char only.
//
// Ports
//   clk     : system clock
//   rst_n   : asynchronous active-low reset. It aborts any frame in flight.
//   trmt    : start request. It is edge-qualified, so one message is sent per
//             low-to-high request seen while idle.
//   tx_data : result byte. The digit is in [3:0]; [7:4] is ignored.
//   TX      : UART serial output, idle high, driven straight from a flop
//   tx_done : one-cycle pulse after the last stop bit of the message
//   busy    : high while a message is in progress
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module result_uart_tx #(
  parameter int BAUD_DIV  = 434,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy
);

  localparam int              CNT_W     = 16;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  // Index of the final byte of the message: char, CR, LF or char alone.
  localparam logic [1:0]      LAST_IDX  = SEND_CRLF ? 2'd2 : 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic [1:0]       r_byte_idx;
  logic [7:0]       r_char;
  logic [7:0]       r_shift;
  logic             r_armed;
  logic             r_tx;
  logic             r_tx_done;
  logic             r_busy;

  logic             w_baud_end;
  logic [7:0]       w_digit;
  logic [7:0]       w_cur_byte;

  // Maps the masked digit byte to ASCII. Out-of-range values map to '?'.
  function automatic logic [7:0] digit_to_ascii(input logic [7:0] d);
    if (d <= 8'd9) begin
      return 8'h30 | d;
    end
    return 8'h3F;
  endfunction

  // The upper nibble carries no information, so it is masked off before mapping.
  assign w_digit    = tx_data & 8'h0F;
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  always_comb begin
    w_cur_byte = 8'h0A;
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_char;
      2'd1:    w_cur_byte = 8'h0D;
      default: w_cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_char     <= 8'h30;
      r_shift    <= '0;
      r_armed    <= 1'b1;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;

      // The baud counter free-runs only while a message is active.
      // Entering START from IDLE always restarts it at zero.
      if (r_state == IDLE) begin
        r_baud_cnt <= '0;
      end else if (w_baud_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 16'd1;
      end

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          // r_armed is set only once trmt has been seen low while idle.
          // This blocks three cases: a held trmt, a trmt sampled during the
          // tx_done cycle, and a trmt that arrived while busy.
          if (trmt && r_armed) begin
            r_char     <= digit_to_ascii(w_digit);
            r_byte_idx <= 2'd0;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_armed    <= 1'b0;
            r_state    <= START;
          end else if (!trmt) begin
            r_armed <= 1'b1;
          end
        end

        START: begin
          if (w_baud_end) begin
            r_shift   <= w_cur_byte;
            r_tx      <= w_cur_byte[0];
            r_bit_cnt <= 3'd0;
            r_state   <= DATA;
          end
        end

        DATA: begin
          if (w_baud_end) begin
            if (r_bit_cnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              // Bit 0 already left at START exit, so the next bit is [1].
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end

        STOP: begin
          if (w_baud_end) begin
            if (r_byte_idx != LAST_IDX) begin
              // Back-to-back: the next start bit follows with no idle gap.
              r_byte_idx <= r_byte_idx + 2'd1;
              r_tx       <= 1'b0;
              r_state    <= START;
            end else begin
              r_busy    <= 1'b0;
              r_tx_done <= 1'b1;
              r_state   <= IDLE;
            end
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign TX      = r_tx;
  assign tx_done = r_tx_done;
  assign busy    = r_busy;

endmodule

// File: tb/tb_result_uart_tx.sv
`timescale 1ns/1ps

module tb_result_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       trmt_a, trmt_b;
  logic [7:0] data_a, data_b;
  logic       tx_a, tx_b, done_a, done_b, busy_a, busy_b;

  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;   // 0: BAUD_DIV=4 with CRLF, 1: BAUD_DIV=5 digit only

  result_uart_tx #(.BAUD_DIV(4), .SEND_CRLF(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_a), .tx_data(data_a),
    .TX(tx_a), .tx_done(done_a), .busy(busy_a)
  );

  result_uart_tx #(.BAUD_DIV(5), .SEND_CRLF(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_b), .tx_data(data_b),
    .TX(tx_b), .tx_done(done_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at position pos (0..9) of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic set_trmt(input logic v);
    if (sel != 0) trmt_b = v; else trmt_a = v;
  endtask

  task automatic set_data(input logic [7:0] v);
    if (sel != 0) data_b = v; else data_a = v;
  endtask

  // Called at a negedge. Sends one message and checks the waveform cycle by
  // cycle, the decoded bytes, the latency of tx_done and its single pulse.
  task automatic send_msg(input string name, input logic [7:0] data,
                          input logic [7:0] c0, input int retrig_at,
                          input bit trmt_on_done);
    int B, N, total, wave_err, busy_err, done_err, bi, pos, off;
    logic t, d, bz;
    logic [7:0] exp_b [0:2];
    logic [7:0] got_b [0:2];
    B = (sel != 0) ? 5 : 4;
    N = (sel != 0) ? 1 : 3;
    total = 10 * B * N;
    exp_b[0] = c0; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
    got_b[0] = 8'h00; got_b[1] = 8'h00; got_b[2] = 8'h00;
    wave_err = 0; busy_err = 0; done_err = 0;
    set_data(data);
    set_trmt(1'b1);
    @(posedge clk);  // edge E0
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      t  = (sel != 0) ? tx_b   : tx_a;
      d  = (sel != 0) ? done_b : done_a;
      bz = (sel != 0) ? busy_b : busy_a;
      if (k < total) begin
        bi  = k / (10 * B);
        pos = (k / B) % 10;
        off = k % B;
        if (t !== frame_bit(exp_b[bi], pos)) wave_err++;
        if (bz !== 1'b1) busy_err++;
        if (d !== 1'b0) done_err++;
        if (off == B / 2 && pos >= 1 && pos <= 8) got_b[bi][pos-1] = t;
      end else begin
        n_checks++;
        if (d !== 1'b1) $display("FAIL %s done_latency: tx_done=%b at +%0d cycles, expected 1", name, d, total);
        else n_pass++;
        n_checks++;
        if (bz !== 1'b0) $display("FAIL %s busy_fall: busy=%b with tx_done, expected 0", name, bz);
        else n_pass++;
      end
      if (k == 0) set_trmt(1'b0);
      if (k == retrig_at) begin
        set_trmt(1'b1);
        set_data(8'h02);
      end
      if (k == retrig_at + 1) set_trmt(1'b0);
      if (k == total && trmt_on_done) set_trmt(1'b1);
    end
    @(negedge clk);
    if (trmt_on_done) set_trmt(1'b0);
    d = (sel != 0) ? done_b : done_a;
    n_checks++;
    if (d !== 1'b0) $display("FAIL %s done_single: tx_done=%b one cycle later, expected 0", name, d);
    else n_pass++;
    n_checks++;
    if (wave_err !== 0) $display("FAIL %s tx_wave: %0d bad TX cycles, expected 0", name, wave_err);
    else n_pass++;
    n_checks++;
    if (busy_err !== 0) $display("FAIL %s busy_high: %0d cycles busy low, expected 0", name, busy_err);
    else n_pass++;
    n_checks++;
    if (done_err !== 0) $display("FAIL %s done_early: %0d early tx_done cycles, expected 0", name, done_err);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (got_b[i] !== exp_b[i]) $display("FAIL %s byte%0d: got 0x%02h, expected 0x%02h", name, i, got_b[i], exp_b[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_a, done_a, busy_a} !== 3'b100) $display("FAIL reset_a: TX/done/busy=%b%b%b, expected 100", tx_a, done_a, busy_a);
    else n_pass++;
    n_checks++;
    if ({tx_b, done_b, busy_b} !== 3'b100) $display("FAIL reset_b: TX/done/busy=%b%b%b, expected 100", tx_b, done_b, busy_b);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_digit();
    sel = 0;
    send_msg("digit7", 8'h07, 8'h37, -10, 1'b0);
  endtask

  task automatic test_out_of_range();
    sel = 0;
    send_msg("oor_0C", 8'h0C, 8'h3F, -10, 1'b0);
  endtask

  task automatic test_upper_bits();
    sel = 0;
    send_msg("upper_F3", 8'hF3, 8'h33, -10, 1'b0);
  endtask

  task automatic test_digit_only();
    sel = 1;
    send_msg("digit_only", 8'h00, 8'h30, -10, 1'b0);
    sel = 0;
  endtask

  task automatic test_retrigger();
    sel = 0;
    send_msg("retrig20", 8'h07, 8'h37, 20, 1'b0);
  endtask

  // A trmt pulse during the tx_done cycle must not start a message.
  task automatic test_trmt_on_done();
    int busy_seen;
    sel = 0;
    send_msg("trmt_on_done", 8'h04, 8'h34, -10, 1'b1);
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || tx_a !== 1'b1) busy_seen++;
    end
    n_checks++;
    if (busy_seen !== 0) $display("FAIL done_cycle_ignore: %0d cycles active, expected 0", busy_seen);
    else n_pass++;
  endtask

  // The second message is requested in the cycle right after tx_done.
  task automatic test_back_to_back();
    sel = 0;
    send_msg("b2b_first", 8'h01, 8'h31, -10, 1'b0);
    send_msg("b2b_second", 8'h08, 8'h38, -10, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    sel = 0;
    data_a = 8'h05;
    trmt_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 49; k++) begin
      @(negedge clk);
      if (k == 0) trmt_a = 1'b0;
    end
    // Cycle 49 is data bit 1 of CR (0x0D), which is a 0 on the line.
    n_checks++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL midframe_pre: TX=%b busy=%b, expected 0 1", tx_a, busy_a);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL midframe_async: TX=%b busy=%b, expected 1 0", tx_a, busy_a);
    else n_pass++;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_a !== 1'b0 || tx_a !== 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) $display("FAIL midframe_no_done: %0d bad cycles, expected 0", done_seen);
    else n_pass++;
    send_msg("after_reset", 8'h09, 8'h39, -10, 1'b0);
  endtask

  initial begin
    trmt_a = 1'b0; trmt_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    rst_n  = 1'b1;
    test_reset();
    test_single_digit();
    test_out_of_range();
    test_upper_bits();
    test_digit_only();
    test_retrigger();
    test_trmt_on_done();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
